// File: rtl/serdes_pkg.sv
// Shared constants and types for the 8-bit serial shift link.
// Used by both the transmitter and the receive deserializer.
package serdes_pkg;

  localparam int LEN_DEFAULT = 8;
  localparam int FIFO_DEPTH  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_e;

endpackage

// File: rtl/serial_deserializer_if.sv
// Parallel valid/ready word port of the deserializer.
// master drives words, slave is the downstream consumer.
import serdes_pkg::*;

interface serial_deserializer_if #(
  parameter int Len = LEN_DEFAULT
);

  logic [Len-1:0] data_out;
  logic           valid;
  logic           ready;

  modport master (
    output data_out,
    output valid,
    input  ready
  );

  modport slave (
    input  data_out,
    input  valid,
    output ready
  );

endinterface

// File: rtl/word_fifo2.sv
// Two-entry register FIFO for completed words.
// A push while full only lands if a pop frees the head slot.
import serdes_pkg::*;

module word_fifo2 #(
  parameter int W = LEN_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] data_in,
  input  logic         pop,
  output logic [W-1:0] data_out,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem_q [2];
  logic         rp_q;
  logic         wp_q;
  logic [1:0]   cnt_q;
  logic         do_push;
  logic         do_pop;

  assign empty   = (cnt_q == 2'd0);
  assign full    = (cnt_q == 2'(FIFO_DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Gate to zero when empty so the idle port reads as reset.
  assign data_out = empty ? '0 : mem_q[rp_q];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rp_q     <= 1'b0;
      wp_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else if (!clr) begin
      rp_q     <= 1'b0;
      wp_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wp_q] <= data_in;
        wp_q        <= ~wp_q;
      end
      if (do_pop) begin
        rp_q <= ~rp_q;
      end
      cnt_q <= cnt_q + 2'(do_push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/serial_deserializer.sv
// Receive side of the serial shift link: MSB-first shift-in,
// word assembly, 2-deep buffering and sticky overrun.
import serdes_pkg::*;

module serial_deserializer #(
  parameter int Len = LEN_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic si,
  input  logic clr,
  serial_deserializer_if.master out,
  output logic ovr,
  output logic busy
);

  localparam int CW = $clog2(Len);
  localparam logic [CW-1:0] LAST = CW'(Len - 1);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [Len-2:0] sh_q, sh_d;
  logic           ovr_q, ovr_d;

  logic           shift;
  logic           done;
  logic           pop;
  logic           full;
  logic           empty;
  logic [Len-1:0] word;

  assign shift = !en;
  assign done  = shift && (cnt_q == LAST);
  assign word  = {sh_q, si};
  assign pop   = out.valid && out.ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    ovr_d   = ovr_q;
    if (!clr) begin
      state_d = IDLE;
      cnt_d   = '0;
      sh_d    = '0;
      ovr_d   = 1'b0;
    end else begin
      if (shift) begin
        sh_d  = word[Len-2:0];
        cnt_d = done ? '0 : cnt_q + 1'b1;
      end
      unique case (state_q)
        IDLE: if (shift && !done) state_d = RECV;
        RECV: if (done) state_d = IDLE;
        default: state_d = IDLE;
      endcase
      // A pop on the same edge makes room, so no drop.
      if (done && full && !pop) ovr_d = 1'b1;
    end
  end

  word_fifo2 #(.W(Len)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .push     (done),
    .data_in  (word),
    .pop      (pop),
    .data_out (out.data_out),
    .full     (full),
    .empty    (empty)
  );

  assign out.valid = !empty;
  assign ovr       = ovr_q;
  assign busy      = (state_q == RECV);

endmodule

// File: tb/tb_serial_deserializer.sv
// Self-checking bench for serial_deserializer with a queue-based
// word-level reference model and randomized traffic.
module tb_serial_deserializer;

  logic clk;
  logic rst;
  logic en;
  logic si;
  logic clr;
  logic ovr;
  logic busy;

  int nvec;
  int nerr;

  int       m_bits;
  int       m_acc;
  bit [7:0] m_q [$];
  bit       m_ovr;

  serial_deserializer_if #(.Len(8)) bus ();

  serial_deserializer #(.Len(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .si   (si),
    .clr  (clr),
    .out  (bus),
    .ovr  (ovr),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    m_bits = 0;
    m_acc  = 0;
    m_q.delete();
    m_ovr  = 1'b0;
  endfunction

  // Advance the model by one clock using the driven inputs, then clock.
  task automatic tick();
    bit       pop;
    bit       done;
    bit [7:0] w;
    done = 1'b0;
    w    = 8'h00;
    if (!clr) begin
      model_reset();
    end else begin
      pop = (m_q.size() > 0) && bus.ready;
      if (!en) begin
        m_acc  = ((m_acc * 2) + int'(si)) % 256;
        m_bits = m_bits + 1;
        if (m_bits == 8) begin
          done   = 1'b1;
          w      = 8'(m_acc);
          m_bits = 0;
          m_acc  = 0;
        end
      end
      if (pop) void'(m_q.pop_front());
      if (done) begin
        if (m_q.size() < 2) m_q.push_back(w);
        else m_ovr = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      en = 1'b0;
      si = b[i];
      tick();
    end
    en = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    en = 1'b1; si = 1'b0; clr = 1'b1;
    bus.ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    nvec++;
    if (bus.valid !== 1'b0) begin
      nerr++;
      $display("FAIL rst_valid got %b want 0", bus.valid);
    end
    nvec++;
    if (bus.data_out !== 8'h00) begin
      nerr++;
      $display("FAIL rst_data got %h want 00", bus.data_out);
    end
    nvec++;
    if (ovr !== 1'b0 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL rst_flags got ovr=%b busy=%b want 0 0",
               ovr, busy);
    end
    #2 rst = 1'b1;
  endtask

  task automatic test_basic();
    logic [7:0] b;
    b = 8'hA5;
    bus.ready = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      en = 1'b0;
      si = b[i];
      tick();
      if (i > 0) begin
        nvec++;
        if (busy !== 1'b1 || bus.valid !== 1'b0) begin
          nerr++;
          $display("FAIL basic_bit%0d got busy=%b valid=%b want 1 0",
                   7 - i, busy, bus.valid);
        end
      end
    end
    en = 1'b1;
    nvec++;
    if (bus.valid !== 1'b1 || bus.data_out !== 8'hA5) begin
      nerr++;
      $display("FAIL basic_word got v=%b d=%h want 1 a5",
               bus.valid, bus.data_out);
    end
    nvec++;
    if (busy !== 1'b0) begin
      nerr++;
      $display("FAIL basic_busy_end got %b want 0", busy);
    end
    tick();
    nvec++;
    if (bus.valid !== 1'b0) begin
      nerr++;
      $display("FAIL basic_one_cycle got valid=%b want 0", bus.valid);
    end
  endtask

  task automatic test_gapped();
    logic [7:0] b;
    int gaps [3] = '{0, 3, 1};
    b = 8'h3C;
    bus.ready = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      en = 1'b0;
      si = b[i];
      tick();
      if (i > 0) begin
        for (int g = 0; g < gaps[(7 - i) % 3]; g++) begin
          en = 1'b1;
          si = 1'($urandom);
          tick();
        end
        nvec++;
        if (bus.valid !== 1'b0) begin
          nerr++;
          $display("FAIL gap_early bit%0d got valid=%b want 0",
                   7 - i, bus.valid);
        end
      end
    end
    en = 1'b1;
    nvec++;
    if (bus.valid !== 1'b1 || bus.data_out !== 8'h3C) begin
      nerr++;
      $display("FAIL gap_word got v=%b d=%h want 1 3c",
               bus.valid, bus.data_out);
    end
    tick();
  endtask

  task automatic test_overrun();
    bus.ready = 1'b0;
    send(8'h11);
    send(8'h22);
    nvec++;
    if (ovr !== 1'b0) begin
      nerr++;
      $display("FAIL ovr_early got %b want 0", ovr);
    end
    send(8'h33);
    nvec++;
    if (ovr !== 1'b1) begin
      nerr++;
      $display("FAIL ovr_set got %b want 1", ovr);
    end
    nvec++;
    if (bus.valid !== 1'b1 || bus.data_out !== 8'h11) begin
      nerr++;
      $display("FAIL ovr_head got v=%b d=%h want 1 11",
               bus.valid, bus.data_out);
    end
    bus.ready = 1'b1;
    tick();
    nvec++;
    if (bus.valid !== 1'b1 || bus.data_out !== 8'h22) begin
      nerr++;
      $display("FAIL ovr_second got v=%b d=%h want 1 22",
               bus.valid, bus.data_out);
    end
    tick();
    nvec++;
    if (bus.valid !== 1'b0 || ovr !== 1'b1) begin
      nerr++;
      $display("FAIL ovr_drain got v=%b ovr=%b want 0 1",
               bus.valid, ovr);
    end
    clr = 1'b0;
    tick();
    clr = 1'b1;
    nvec++;
    if (ovr !== 1'b0) begin
      nerr++;
      $display("FAIL ovr_clr got %b want 0", ovr);
    end
  endtask

  task automatic test_push_pop_full();
    logic [7:0] b;
    b = 8'hCC;
    bus.ready = 1'b0;
    send(8'hAA);
    send(8'hBB);
    for (int i = 7; i >= 1; i--) begin
      en = 1'b0;
      si = b[i];
      tick();
    end
    bus.ready = 1'b1;
    en = 1'b0;
    si = b[0];
    tick();
    en = 1'b1;
    nvec++;
    if (ovr !== 1'b0 || bus.data_out !== 8'hBB) begin
      nerr++;
      $display("FAIL pp_full got ovr=%b d=%h want 0 bb",
               ovr, bus.data_out);
    end
    tick();
    nvec++;
    if (bus.valid !== 1'b1 || bus.data_out !== 8'hCC) begin
      nerr++;
      $display("FAIL pp_third got v=%b d=%h want 1 cc",
               bus.valid, bus.data_out);
    end
    tick();
    nvec++;
    if (bus.valid !== 1'b0 || ovr !== 1'b0) begin
      nerr++;
      $display("FAIL pp_end got v=%b ovr=%b want 0 0",
               bus.valid, ovr);
    end
  endtask

  task automatic test_clear();
    bus.ready = 1'b0;
    send(8'h77);
    for (int i = 0; i < 5; i++) begin
      en = 1'b0;
      si = 1'b1;
      tick();
    end
    en = 1'b1;
    nvec++;
    if (busy !== 1'b1 || bus.valid !== 1'b1) begin
      nerr++;
      $display("FAIL clr_pre got busy=%b v=%b want 1 1",
               busy, bus.valid);
    end
    clr = 1'b0;
    en = 1'b0;
    tick();
    clr = 1'b1;
    en = 1'b1;
    nvec++;
    if (busy !== 1'b0 || bus.valid !== 1'b0) begin
      nerr++;
      $display("FAIL clr_post got busy=%b v=%b want 0 0",
               busy, bus.valid);
    end
    bus.ready = 1'b1;
    send(8'h81);
    nvec++;
    if (bus.valid !== 1'b1 || bus.data_out !== 8'h81) begin
      nerr++;
      $display("FAIL clr_word got v=%b d=%h want 1 81",
               bus.valid, bus.data_out);
    end
    tick();
    nvec++;
    if (bus.valid !== 1'b0) begin
      nerr++;
      $display("FAIL clr_only got valid=%b want 0", bus.valid);
    end
  endtask

  task automatic test_reset_mid();
    bus.ready = 1'b0;
    send(8'h5A);
    send(8'h6B);
    send(8'h7C);
    for (int i = 0; i < 5; i++) begin
      en = 1'b0;
      si = 1'b1;
      tick();
    end
    en = 1'b1;
    #3 rst = 1'b0;
    #1;
    nvec++;
    if (bus.valid !== 1'b0 || bus.data_out !== 8'h00) begin
      nerr++;
      $display("FAIL rmid_port got v=%b d=%h want 0 00",
               bus.valid, bus.data_out);
    end
    nvec++;
    if (ovr !== 1'b0 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL rmid_flags got ovr=%b busy=%b want 0 0",
               ovr, busy);
    end
    #3 rst = 1'b1;
    model_reset();
    bus.ready = 1'b1;
    send(8'h81);
    nvec++;
    if (bus.valid !== 1'b1 || bus.data_out !== 8'h81) begin
      nerr++;
      $display("FAIL rmid_word got v=%b d=%h want 1 81",
               bus.valid, bus.data_out);
    end
    tick();
  endtask

  task automatic test_random();
    bit [7:0] exp_d;
    for (int c = 0; c < 3000; c++) begin
      en        = ($urandom_range(0, 9) < 4);
      si        = 1'($urandom);
      bus.ready = (c % 400 < 200) ? ($urandom_range(0, 3) == 0)
                                  : ($urandom_range(0, 3) != 0);
      clr       = ($urandom_range(0, 149) != 0);
      tick();
      exp_d = (m_q.size() > 0) ? m_q[0] : 8'h00;
      nvec++;
      if (bus.valid !== (m_q.size() > 0)) begin
        nerr++;
        $display("FAIL rnd_valid c%0d got %b want %b",
                 c, bus.valid, m_q.size() > 0);
      end
      if (m_q.size() > 0) begin
        nvec++;
        if (bus.data_out !== exp_d) begin
          nerr++;
          $display("FAIL rnd_data c%0d got %h want %h",
                   c, bus.data_out, exp_d);
        end
      end
      nvec++;
      if (ovr !== m_ovr || busy !== (m_bits > 0)) begin
        nerr++;
        $display("FAIL rnd_flags c%0d got ovr=%b busy=%b want %b %b",
                 c, ovr, busy, m_ovr, m_bits > 0);
      end
    end
    clr = 1'b1;
    en  = 1'b1;
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    test_reset();
    test_basic();
    test_gapped();
    test_overrun();
    test_push_pop_full();
    test_clear();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
